// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   DEFAULT_WIDTH : default operand width
//   state_e       : controller state encoding
package seq_multiplier_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : seq_multiplier_pkg

// File: rtl/add_nbit.sv
// Parametrised ripple-carry adder with carry-out.
// Ports:
//   a_i, b_i  : WIDTH-bit addends
//   cin_i     : carry in
//   sum_c_o   : WIDTH-bit sum (combinational)
//   cout_c_o  : carry out (combinational)
module add_nbit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_c_o,
    output logic             cout_c_o
);

    logic [WIDTH:0] carry;

    // Bit-serial carry chain
    always_comb begin
        carry    = '0;
        sum_c_o  = '0;
        carry[0] = cin_i;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_c_o[i]  = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_c_o = carry[WIDTH];
    end

endmodule : add_nbit

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one partial product per cycle.
// Signed operands are converted to magnitudes at start; the sign is
// re-applied in the DONE cycle. Fixed latency WIDTH+1 cycles from the
// accepting edge to the done pulse.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : launch request, honoured only in IDLE
//   signed_mode   : 1 = two's-complement operands
//   x, y          : multiplicand, multiplier
//   busy          : high while iterating
//   done          : one-cycle result-valid pulse
//   product       : 2*WIDTH-bit result, held
//   overflow      : result does not fit WIDTH bits in the selected mode
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    localparam int unsigned PW = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               smode_q, smode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PW-1:0]      product_q, product_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH-1:0]   addend_c;
    logic [WIDTH-1:0]   add_sum_c;
    logic               add_cout_c;
    logic [WIDTH:0]     step_c;
    logic [WIDTH-1:0]   x_mag_c;
    logic [WIDTH-1:0]   y_mag_c;
    logic [PW-1:0]      mag_c;
    logic [PW-1:0]      result_c;
    logic               ovf_c;

    // Partial product: add multiplicand only when multiplier LSB is set
    assign addend_c = mult_q[0] ? mcand_q : '0;

    add_nbit #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i      (acc_q),
        .b_i      (addend_c),
        .cin_i    (1'b0),
        .sum_c_o  (add_sum_c),
        .cout_c_o (add_cout_c)
    );

    assign step_c = {add_cout_c, add_sum_c};

    // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1)
    assign x_mag_c = (signed_mode && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    assign y_mag_c = (signed_mode && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;

    // Sign restore, skipped for a zero magnitude so -0 never appears
    assign mag_c    = {acc_q, mult_q};
    assign result_c = (neg_q && (mag_c != '0)) ? (~mag_c + PW'(1)) : mag_c;

    // Overflow: upper half must be a pure extension of the lower half
    always_comb begin
        ovf_c = 1'b0;
        if (smode_q) begin
            ovf_c = !((result_c[PW-1:WIDTH-1] == '0) ||
                      (result_c[PW-1:WIDTH-1] == '1));
        end else begin
            ovf_c = (result_c[PW-1:WIDTH] != '0);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mult_d     = mult_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        smode_d    = smode_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        product_d  = product_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d    = x_mag_c;
                    mult_d     = y_mag_c;
                    acc_d      = '0;
                    cnt_d      = '0;
                    neg_d      = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
                    smode_d    = signed_mode;
                    product_d  = '0;
                    overflow_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // Shift {carry,sum,mult} right by one
                acc_d  = step_c[WIDTH:1];
                mult_d = {step_c[0], mult_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                product_d  = result_c;
                overflow_d = ovf_c;
                done_d     = 1'b1;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mult_q     <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            smode_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mult_q     <= mult_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            smode_q    <= smode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=16.
module tb_seq_multiplier;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           overflow;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic        o;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer multiply with range test
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic m,
                         output logic [31:0] p, output logic o);
        longint pa, pb, pr;
        if (m) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({48'd0, a});
            pb = longint'({48'd0, b});
        end
        pr = pa * pb;
        p  = 32'(pr);
        o  = m ? ((pr < -32768) || (pr > 32767)) : (pr > 65535);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 6))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            check("busy_with_done", 64'(busy), 64'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(exp_q.size()), 64'(1));
            end else begin
                mon_e = exp_q.pop_front();
                check("product", 64'(product), 64'(mon_e.p));
                check("overflow", 64'(overflow), 64'(mon_e.o));
                check("latency", 64'(cyc), 64'(mon_e.cyc + 17));
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m);
        exp_t e;
        @(negedge clk);
        start       = 1'b1;
        x           = a;
        y           = b;
        signed_mode = m;
        model(a, b, m, e.p, e.o);
        @(posedge clk);
        #1;
        e.cyc = cyc;
        exp_q.push_back(e);
        start       = 1'b0;
        x           = 16'($urandom);
        y           = 16'($urandom);
        signed_mode = 1'($urandom);
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
            #1;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        x           = '0;
        y           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        check("reset_overflow", 64'(overflow), 64'(0));
        reset = 1'b0;

        // Directed cases
        issue(16'd7, 16'd9, 1'b0);        wait_drain();
        issue(16'hFFFD, 16'd5, 1'b1);     wait_drain();
        issue(16'h0000, 16'hFFFF, 1'b1);  wait_drain();
        issue(16'hFFFF, 16'hFFFF, 1'b0);  wait_drain();
        issue(16'h8000, 16'h8000, 1'b1);  wait_drain();

        // Start pulse during RUN must be ignored
        issue(16'd3, 16'd4, 1'b0);
        idle(4);
        start = 1'b1;
        x     = 16'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        idle(25);
        check("idle_after_ignored", 64'(busy), 64'(0));

        // Start held high: relaunch on first IDLE cycle after DONE
        @(negedge clk);
        start       = 1'b1;
        x           = 16'hFF12;
        y           = 16'h0123;
        signed_mode = 1'b1;
        model(16'hFF12, 16'h0123, 1'b1, e1.p, e1.o);
        @(posedge clk);
        #1;
        e1.cyc = cyc;
        e2     = e1;
        e2.cyc = e1.cyc + 18;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        repeat (18) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        idle(25);

        // Reset mid-operation discards the operation
        @(negedge clk);
        start       = 1'b1;
        x           = 16'h1234;
        y           = 16'h0010;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_product", 64'(product), 64'(0));
        check("midreset_overflow", 64'(overflow), 64'(0));
        idle(25);
        issue(16'd2, 16'd3, 1'b0);
        wait_drain();

        // Randomised operands biased toward corner values
        for (int i = 0; i < 40; i++) begin
            issue(pick(), pick(), 1'($urandom));
            wait_drain();
        end

        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal values are 4..32.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+1), giving the iteration counter width.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit: request a multiply; sampled only in IDLE.
REQ-006 Port signed_mode SHALL be an input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 Ports x and y SHALL be inputs, WIDTH bits each: multiplicand and multiplier, sampled with start.
REQ-008 Port busy SHALL be an output, 1 bit: high while in RUN.
REQ-009 Port done SHALL be an output, 1 bit: single-cycle pulse when the product becomes valid.
REQ-010 Port product SHALL be an output, 2*WIDTH bits: full-width result, held until the next accepted start or reset.
REQ-011 Port overflow SHALL be an output, 1 bit: the result does not fit in WIDTH bits under the selected mode; held with product.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; reset and power-up SHALL go to IDLE.
REQ-013 In IDLE with start=1 at edge N, the block SHALL latch x, y and signed_mode, clear the accumulator and counter, and enter RUN.
REQ-014 In RUN, the block SHALL perform one shift-add step per cycle: if multiplier LSB=1, accumulator += multiplicand (WIDTH+1-bit add, carry kept); then shift {acc,mult} right by one.
REQ-015 RUN SHALL last exactly WIDTH cycles, with no early termination on zero operands, then go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1 and product/overflow valid, then return to IDLE; done SHALL be asserted in the cycle after edge N+WIDTH+1, giving fixed latency WIDTH+1 cycles.
REQ-017 Signed mode SHALL multiply magnitudes (|x|, |y| as WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1)), then two's-complement negate the 2*WIDTH result if sign(x) XOR sign(y), and only if the magnitude result is nonzero.
REQ-018 Overflow SHALL be computed as follows: unsigned mode, product[2W-1:W] != 0; signed mode, product[2W-1:W-1] not all-equal.
REQ-019 start asserted in RUN or DONE SHALL be ignored; no queuing; start held high SHALL launch a new operation on the first IDLE cycle after DONE.
REQ-020 Operand or signed_mode changes during RUN SHALL have no effect on the result.
REQ-021 busy SHALL equal (state==RUN); busy and done SHALL never be high together.

Reset
REQ-022 On reset=1 at a rising edge, in any state including mid-RUN: state=IDLE, busy=0, done=0, product=0, overflow=0, counter=0; the in-flight operation SHALL be discarded with no done pulse.
REQ-023 Reset SHALL take priority over start in the same cycle.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-025 The accumulate step SHALL use one sub-module, add_nbit (a parametrised ripple adder with carry-out); the FSM, counter and shift registers SHALL stay in seq_multiplier.

Verification (WIDTH=16)
REQ-026 Unsigned basic: start, x=7, y=9, mode=0 -> done exactly 17 cycles after the start edge, product=0x0000003F, overflow=0.
REQ-027 Signed mixed: x=0xFFFD (-3), y=5, mode=1 -> product=0xFFFFFFF1, overflow=0; then x=0, y=0xFFFF, mode=1 -> product=0, overflow=0.
REQ-028 Extremes: x=y=0xFFFF, mode=0 -> product=0xFFFE0001, overflow=1; x=y=0x8000, mode=1 -> product=0x40000000, overflow=1.
REQ-029 Ignored start: start x=3, y=4; pulse start with x=100 at cycle 5 of RUN -> product=12, only one done pulse.
REQ-030 Reset mid-op: start x=0x1234, y=0x10; assert reset at cycle 8 -> next cycle busy=0, product=0, no done; new start x=2, y=3 -> product=6.
